// File: rtl/rv_pkg.sv
// Shared register-file constants, requester indices and a small index helper
// used by the write-back scheduler and its arbiter.
package rv_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

  localparam int WB_ALU = 0;
  localparam int WB_LSU = 1;
  localparam int WB_CSR = 2;

  typedef logic [REG_AW-1:0] reg_addr_t;

  // One-hot decode of a register address, with x0 never represented.
  function automatic logic [31:0] reg_mask(input reg_addr_t a);
    logic [31:0] m;
    m = 32'd1 << a;
    return m & ~32'd1;
  endfunction

endpackage

// File: rtl/regfile_wb_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot grant scanning from the pointer, and the
// pointer moves just past the winner whenever a grant is issued.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);

  localparam int PW = $clog2(N);

  logic [PW-1:0] ptr_r;
  logic [PW-1:0] gidx;
  logic          found;
  logic          hit;
  int            ptr_i;

  // Two passes (indices at/after the pointer, then before it) give the
  // wrapped priority order without any modulo arithmetic.
  always_comb begin
    gnt   = '0;
    gidx  = '0;
    found = 1'b0;
    hit   = 1'b0;
    ptr_i = int'(ptr_r);
    for (int j = 0; j < N; j++) begin
      hit    = ~found & req[j] & (j >= ptr_i);
      gnt[j] = gnt[j] | hit;
      gidx   = hit ? j[PW-1:0] : gidx;
      found  = found | hit;
    end
    for (int j = 0; j < N; j++) begin
      hit    = ~found & req[j] & (j < ptr_i);
      gnt[j] = gnt[j] | hit;
      gidx   = hit ? j[PW-1:0] : gidx;
      found  = found | hit;
    end
  end

  // Pointer advances to winner+1 (wrapping) on a grant, else holds.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_r <= {PW{1'b0}};
    end else if (found) begin
      ptr_r <= (gidx == PW'(N - 1)) ? {PW{1'b0}} : gidx + PW'(1);
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/regfile_wb_sched.sv
// Write-back scheduler and RAW scoreboard for the single-write-port register
// file. Optional operand bypass from the commit stage: RF_WB_BYPASS_EN.
module regfile_wb_sched
  import rv_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int XLEN = rv_pkg::XLEN
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*5-1:0]    req_rd,
  input  logic [NREQ*XLEN-1:0] req_data,
  input  logic                 alloc_valid,
  input  logic [4:0]           alloc_rd,
  output logic                 alloc_ready,
  input  logic [4:0]           rs1,
  input  logic [4:0]           rs2,
  output logic                 hazard,
  input  logic [XLEN-1:0]      rf_rdata1,
  input  logic [XLEN-1:0]      rf_rdata2,
  output logic [XLEN-1:0]      rdata1,
  output logic [XLEN-1:0]      rdata2,
  output logic                 rf_we,
  output logic [4:0]           rf_waddr,
  output logic [XLEN-1:0]      rf_wdata
);

  logic [NREQ-1:0]   gnt;
  logic [REG_AW-1:0] sel_rd;
  logic [XLEN-1:0]   sel_data;
  logic [31:0]       busy_r;
  logic [31:0]       busy_next;
  logic              alloc_fire;
  logic              fwd1;
  logic              fwd2;

  rr_arbiter #(.N(NREQ)) u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (req_valid),
    .gnt   (gnt)
  );

  assign req_ready = gnt;

  // AND-OR mux of the granted requester's destination and data.
  always_comb begin
    sel_rd   = REG_ZERO;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      sel_rd   = sel_rd   | (req_rd[5*i +: 5]         & {REG_AW{gnt[i]}});
      sel_data = sel_data | (req_data[XLEN*i +: XLEN] & {XLEN{gnt[i]}});
    end
  end

  // Commit stage: writes to x0 are consumed but never enable the port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_we    <= 1'b0;
      rf_waddr <= REG_ZERO;
      rf_wdata <= '0;
    end else if (|gnt) begin
      rf_we    <= (sel_rd != REG_ZERO);
      rf_waddr <= sel_rd;
      rf_wdata <= sel_data;
    end else begin
      rf_we    <= 1'b0;
      rf_waddr <= rf_waddr;
      rf_wdata <= rf_wdata;
    end
  end

  assign alloc_ready = ~busy_r[alloc_rd];
  assign alloc_fire  = alloc_valid & alloc_ready & (alloc_rd != REG_ZERO);

  // Set and clear are independent bit masks; bit 0 is masked off permanently.
  always_comb begin
    busy_next = (busy_r & ~(rf_we ? reg_mask(rf_waddr) : 32'd0))
              | (alloc_fire ? reg_mask(alloc_rd) : 32'd0);
  end

  // Scoreboard register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_r <= 32'd0;
    end else begin
      busy_r <= busy_next;
    end
  end

`ifdef RF_WB_BYPASS_EN
  assign fwd1   = rf_we & (rf_waddr == rs1) & (rs1 != REG_ZERO);
  assign fwd2   = rf_we & (rf_waddr == rs2) & (rs2 != REG_ZERO);
  assign rdata1 = fwd1 ? rf_wdata : rf_rdata1;
  assign rdata2 = fwd2 ? rf_wdata : rf_rdata2;
`else
  assign fwd1   = 1'b0;
  assign fwd2   = 1'b0;
  assign rdata1 = rf_rdata1;
  assign rdata2 = rf_rdata2;
`endif

  assign hazard = (busy_r[rs1] & ~fwd1) | (busy_r[rs2] & ~fwd2);

endmodule
